// File: rtl/dtim_ahb_port_pkg.sv
// dtim_ahb_port_pkg
// Shared constants for the DTIM bus port:
//   - configuration widths (physical address width, data width, DTIM size)
//   - AHB-Lite HTRANS / HRESP encodings used by every subordinate
//   - dtim_offset(): maps a bus address onto the DTIM index space
package dtim_ahb_port_pkg;

  localparam int PA_BITS    = 32;
  localparam int LLEN       = 64;
  localparam int LLEN_BYTES = LLEN / 8;
  localparam int OFF_BITS   = $clog2(LLEN_BYTES);
  // DTIM size in bytes; must be a power of two
  localparam int DTIM_RANGE = 4096;

  // Largest legal HSIZE is one full data word
  localparam logic [2:0] MAX_HSIZE = 3'(OFF_BITS);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Range decode is external, so the offset simply wraps inside the DTIM
  function automatic logic [PA_BITS-1:0] dtim_offset(input logic [PA_BITS-1:0] addr);
    return addr & PA_BITS'(DTIM_RANGE - 1);
  endfunction

endpackage

// File: rtl/dtim_bytemask.sv
// dtim_bytemask
// Combinational byte-lane decoder for an AHB transfer.
// Ports:
//   hsize    in  transfer size, log2 bytes
//   addr_lo  in  low address bits selecting the byte lane
//   mask     out byte enables: ((1 << 2^hsize) - 1) << addr_lo
//   misalign out address not aligned to 2^hsize
// Oversized transfers are not flagged here; the caller compares hsize
// against its own data width.
module dtim_bytemask #(
  parameter  int LLEN = 64,
  localparam int NB   = LLEN / 8,
  localparam int OFFB = $clog2(NB)
) (
  input  logic [2:0]      hsize,
  input  logic [OFFB-1:0] addr_lo,
  output logic [NB-1:0]   mask,
  output logic            misalign
);

  int lo_s;
  int sz_s;

  // Lane i is enabled when it falls inside [addr_lo, addr_lo + 2^hsize)
  always_comb begin
    lo_s     = int'(addr_lo);
    sz_s     = 32'sd1 <<< hsize;
    misalign = ((lo_s & (sz_s - 32'sd1)) != 32'sd0);
    mask     = '0;
    for (int i = 0; i < NB; i++) begin
      mask[i] = (i >= lo_s) && (i < (lo_s + sz_s));
    end
  end

endmodule

// File: rtl/dtim_ahb_port.sv
// dtim_ahb_port
// AHB-Lite subordinate giving external managers access to the DTIM. The
// RAM port is shared with the core, which has priority; the bus waits
// while blocked and forces a one-cycle core stall once starvation reaches
// STARVE_LIMIT-1 blocked cycles.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   HSEL..HWDATA                AHB-Lite subordinate inputs
//   HRDATA, HREADYOUT, HRESP    AHB-Lite subordinate outputs
//   CoreReqM                    core owns the RAM port this cycle
//   BusStallCore                one-cycle core stall to grant the bus
//   BusDTIMReq                  bus owns the RAM this cycle (mux select)
//   BusDTIMAdr/WE/ByteMask/WriteData  RAM request
//   BusDTIMReadData             RAM q, valid the cycle after a read slot
module dtim_ahb_port
  import dtim_ahb_port_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  HSEL,
  input  logic [PA_BITS-1:0]    HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic [LLEN-1:0]       HWDATA,
  output logic [LLEN-1:0]       HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic                  CoreReqM,
  output logic                  BusStallCore,
  output logic                  BusDTIMReq,
  output logic [PA_BITS-1:0]    BusDTIMAdr,
  output logic                  BusDTIMWE,
  output logic [LLEN_BYTES-1:0] BusDTIMByteMask,
  output logic [LLEN-1:0]       BusDTIMWriteData,
  input  logic [LLEN-1:0]       BusDTIMReadData
);

  localparam int                CNT_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STARVE_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_DATA  = 3'd3,
    S_ERR1     = 3'd4,
    S_ERR2     = 3'd5
  } state_e;

  state_e                 state_r;
  state_e                 state_s;
  state_e                 kind_s;
  logic [PA_BITS-1:0]     addr_r;
  logic                   write_r;
  logic [LLEN_BYTES-1:0]  mask_r;
  logic                   err_r;
  logic [CNT_BITS-1:0]    cnt_r;
  logic [LLEN-1:0]        hrdata_r;

  logic                   xfer_s;
  logic                   accept_s;
  logic [LLEN_BYTES-1:0]  bm_mask_s;
  logic                   misalign_s;
  logic                   err_s;
  logic                   wants_s;
  logic                   stall_s;
  logic                   grant_s;
  logic                   done_s;
  logic                   load_s;

  dtim_bytemask #(.LLEN(LLEN)) u_bytemask (
    .hsize    (HSIZE),
    .addr_lo  (HADDR[OFF_BITS-1:0]),
    .mask     (bm_mask_s),
    .misalign (misalign_s)
  );

  // Address-phase decode: only NONSEQ/SEQ carry a transfer
  always_comb begin
    case (htrans_e'(HTRANS))
      HTRANS_IDLE, HTRANS_BUSY: xfer_s = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: xfer_s = 1'b1;
      default: xfer_s = 1'b0;
    endcase
    accept_s = HSEL & HREADY & xfer_s;
    err_s    = (HSIZE > MAX_HSIZE) | misalign_s;
    if (err_s) begin
      kind_s = S_ERR1;
    end else if (HWRITE) begin
      kind_s = S_WR;
    end else begin
      kind_s = S_RD_ISSUE;
    end
  end

  // Arbitration: the core wins unless starvation forces a stall. Reset
  // suppresses the grant so an abandoned write never reaches the RAM.
  assign wants_s      = (state_r == S_WR) | (state_r == S_RD_ISSUE);
  assign stall_s      = wants_s & CoreReqM & (cnt_r == CNT_LAST) & ~reset;
  assign grant_s      = wants_s & (~CoreReqM | stall_s) & ~reset;
  assign BusStallCore = stall_s;
  assign BusDTIMAdr   = addr_r;

  // Next-state logic; kept apart from the output block so HREADY (often
  // our own HREADYOUT fed back by the interconnect) never loops through it
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      S_IDLE, S_RD_DATA, S_ERR2: done_s = 1'b1;
      S_WR:                      done_s = grant_s;
      default:                   done_s = 1'b0;
    endcase
    if (done_s) begin
      if (accept_s) begin
        state_s = kind_s;
        load_s  = 1'b1;
      end else begin
        state_s = S_IDLE;
        load_s  = 1'b0;
      end
    end else begin
      case (state_r)
        S_WR:       state_s = S_WR;
        S_RD_ISSUE: state_s = grant_s ? S_RD_DATA : S_RD_ISSUE;
        S_ERR1:     state_s = S_ERR2;
        default:    state_s = S_IDLE;
      endcase
    end
  end

  // Bus response and RAM request outputs for the current state
  always_comb begin
    HREADYOUT        = 1'b1;
    HRESP            = HRESP_OKAY;
    HRDATA           = hrdata_r;
    BusDTIMReq       = 1'b0;
    BusDTIMWE        = 1'b0;
    BusDTIMByteMask  = '0;
    BusDTIMWriteData = '0;
    case (state_r)
      S_WR: begin
        if (grant_s) begin
          BusDTIMReq       = 1'b1;
          BusDTIMWE        = write_r;
          BusDTIMByteMask  = mask_r;
          BusDTIMWriteData = HWDATA;
          HREADYOUT        = 1'b1;
        end else begin
          HREADYOUT        = 1'b0;
        end
      end
      S_RD_ISSUE: begin
        HREADYOUT  = 1'b0;
        BusDTIMReq = grant_s;
      end
      S_RD_DATA: begin
        HRDATA = BusDTIMReadData;
      end
      S_ERR1: begin
        HRESP     = err_r ? HRESP_ERROR : HRESP_OKAY;
        HREADYOUT = 1'b0;
      end
      S_ERR2: begin
        HRESP     = err_r ? HRESP_ERROR : HRESP_OKAY;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Address-phase capture
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r  <= '0;
      write_r <= 1'b0;
      mask_r  <= '0;
      err_r   <= 1'b0;
    end else if (load_s) begin
      addr_r  <= dtim_offset(HADDR);
      write_r <= HWRITE;
      mask_r  <= bm_mask_s;
      err_r   <= err_s;
    end
  end

  // Starvation counter: counts blocked cycles, cleared by any grant
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (grant_s) begin
      cnt_r <= '0;
    end else if (wants_s) begin
      cnt_r <= cnt_r + CNT_BITS'(1);
    end
  end

  // HRDATA keeps the last returned word outside RD_DATA
  always_ff @(posedge clk) begin
    if (reset) begin
      hrdata_r <= '0;
    end else if (state_r == S_RD_DATA) begin
      hrdata_r <= BusDTIMReadData;
    end
  end

endmodule

// File: tb/tb_dtim_ahb_port.sv
module tb_dtim_ahb_port;
  import dtim_ahb_port_pkg::*;

  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        CoreReqM;
  logic        BusStallCore;
  logic        BusDTIMReq;
  logic [31:0] BusDTIMAdr;
  logic        BusDTIMWE;
  logic [7:0]  BusDTIMByteMask;
  logic [63:0] BusDTIMWriteData;
  logic [63:0] BusDTIMReadData;

  int vectors = 0;
  int miscompares = 0;
  logic prev_stall = 1'b0;
  logic ram_init;
  logic [63:0] ram  [512];
  logic [63:0] gold [512];

  always #5 clk = ~clk;
  assign HREADY = HREADYOUT;

  dtim_ahb_port #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .CoreReqM(CoreReqM),
    .BusStallCore(BusStallCore), .BusDTIMReq(BusDTIMReq), .BusDTIMAdr(BusDTIMAdr),
    .BusDTIMWE(BusDTIMWE), .BusDTIMByteMask(BusDTIMByteMask),
    .BusDTIMWriteData(BusDTIMWriteData), .BusDTIMReadData(BusDTIMReadData)
  );

  // Synchronous RAM with byte enables; q registered one cycle after a read slot
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= '0;
      BusDTIMReadData <= '0;
    end else begin
      if (BusDTIMReq && BusDTIMWE) begin
        for (int b = 0; b < 8; b++)
          if (BusDTIMByteMask[b]) ram[BusDTIMAdr[11:3]][b*8 +: 8] <= BusDTIMWriteData[b*8 +: 8];
      end
      if (BusDTIMReq && !BusDTIMWE) BusDTIMReadData <= ram[BusDTIMAdr[11:3]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample at the falling edge and check the arbitration rules every cycle
  task automatic sample_cycle();
    @(negedge clk);
    if (!reset) begin
      if (!BusDTIMReq) begin
        check("noreq_we", {63'd0, BusDTIMWE}, 64'd0);
        check("noreq_mask", {56'd0, BusDTIMByteMask}, 64'd0);
      end else begin
        check("req_priority", {63'd0, (!CoreReqM || BusStallCore)}, 64'd1);
      end
      check("stall_without_req", {63'd0, (BusStallCore && !BusDTIMReq)}, 64'd0);
      check("stall_two_cycles", {63'd0, (BusStallCore && prev_stall)}, 64'd0);
      prev_stall = BusStallCore;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hreadyout"}, {63'd0, HREADYOUT}, 64'd1);
    check({tag, "_hresp"}, {63'd0, HRESP}, 64'd0);
    check({tag, "_hrdata"}, HRDATA, 64'd0);
    check({tag, "_stall"}, {63'd0, BusStallCore}, 64'd0);
    check({tag, "_req"}, {63'd0, BusDTIMReq}, 64'd0);
    check({tag, "_we"}, {63'd0, BusDTIMWE}, 64'd0);
    check({tag, "_mask"}, {56'd0, BusDTIMByteMask}, 64'd0);
    check({tag, "_adr"}, {32'd0, BusDTIMAdr}, 64'd0);
    check({tag, "_wdata"}, BusDTIMWriteData, 64'd0);
  endtask

  // One non-pipelined transfer; CoreReqM is high for the first 'busy' data-phase cycles
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [63:0] wdata, input int busy,
                      output int cycles, output int stalls, output int stall_at, output int reqs,
                      output logic [7:0] gmask, output logic [31:0] gadr, output logic [63:0] gwdata,
                      output logic [63:0] rdata, output logic resp0, output logic rdy0,
                      output logic respl);
    logic done;
    cycles = 0; stalls = 0; stall_at = 0; reqs = 0; gmask = '0; gadr = '0; gwdata = '0;
    rdata = '0; resp0 = 1'b0; rdy0 = 1'b0; respl = 1'b0; done = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size; CoreReqM = 1'b0;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWDATA = wdata;
    while (!done && cycles < 40) begin
      CoreReqM = (cycles < busy);
      sample_cycle();
      if (cycles == 0) begin resp0 = HRESP; rdy0 = HREADYOUT; end
      if (BusStallCore) begin
        stalls++;
        if (stall_at == 0) stall_at = cycles + 1;
      end
      if (BusDTIMReq) begin
        reqs++; gmask = BusDTIMByteMask; gadr = BusDTIMAdr; gwdata = BusDTIMWriteData;
      end
      cycles++;
      if (HREADYOUT) begin done = 1'b1; rdata = HRDATA; respl = HRESP; end
      @(posedge clk); #1;
    end
    CoreReqM = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL xfer_timeout: no HREADYOUT after %0d cycles, expected completion", cycles);
    end
  endtask

  // Runs a transfer and compares it with the transaction-level model
  task automatic check_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [63:0] wdata, input int busy,
                            output int cycles, output int stall_at, output logic [7:0] gmask,
                            output logic [63:0] rdata);
    int stalls, reqs, sz, lo, k, m, idx, ecyc;
    logic [31:0] gadr; logic [63:0] gwdata; logic resp0, rdy0, respl, err;
    xfer(wr, addr, size, wdata, busy, cycles, stalls, stall_at, reqs, gmask, gadr, gwdata,
         rdata, resp0, rdy0, respl);
    sz  = 1 << size;
    lo  = int'(addr[2:0]);
    err = (size > 3'd3) || ((lo % sz) != 0);
    k   = (busy < SL - 1) ? busy : SL - 1;
    ecyc = err ? 2 : (wr ? k + 1 : k + 2);
    idx = int'(addr % 32'd4096) / 8;
    check({tag, "_cycles"}, 64'(cycles), 64'(ecyc));
    check({tag, "_stalls"}, 64'(stalls), (!err && busy >= SL) ? 64'd1 : 64'd0);
    check({tag, "_reqs"}, 64'(reqs), err ? 64'd0 : 64'd1);
    if (err) begin
      check({tag, "_resp_first"}, {63'd0, resp0}, 64'd1);
      check({tag, "_ready_first"}, {63'd0, rdy0}, 64'd0);
      check({tag, "_resp_last"}, {63'd0, respl}, 64'd1);
    end else begin
      check({tag, "_resp"}, {63'd0, respl}, 64'd0);
      check({tag, "_adr"}, {32'd0, gadr}, 64'(addr % 32'd4096));
      if (busy >= SL) check({tag, "_stall_at"}, 64'(stall_at), 64'(SL));
      if (wr) begin
        m = ((1 << sz) - 1) << lo;
        check({tag, "_mask"}, {56'd0, gmask}, {56'd0, m[7:0]});
        check({tag, "_wdata"}, gwdata, wdata);
        for (int b = 0; b < 8; b++) if (m[b]) gold[idx][b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        check({tag, "_rdata"}, rdata, gold[idx]);
      end
    end
  endtask

  initial begin
    int cyc, sat;
    logic [7:0] gm;
    logic [63:0] rd;
    reset = 1'b1; ram_init = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = '0;
    HTRANS = 2'b00; HWDATA = '0; CoreReqM = 1'b0;
    for (int i = 0; i < 512; i++) gold[i] = '0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; ram_init = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;

    // Word write then read back, no core traffic
    check_xfer("wr_word", 1'b1, 32'h8, 3'd2, 64'h0000_0000_1122_3344, 0, cyc, sat, gm, rd);
    check("wr_word_zero_wait", 64'(cyc), 64'd1);
    check("wr_word_mask_lit", {56'd0, gm}, 64'h0F);
    check_xfer("rd_word", 1'b0, 32'h8, 3'd2, 64'd0, 0, cyc, sat, gm, rd);
    check("rd_word_one_wait", 64'(cyc), 64'd2);
    check("rd_word_data_lit", rd, 64'h0000_0000_1122_3344);

    // Byte write into a known doubleword
    check_xfer("wr_dword", 1'b1, 32'h0, 3'd3, 64'h1122_3344_5566_7788, 0, cyc, sat, gm, rd);
    check_xfer("wr_byte", 1'b1, 32'h3, 3'd0, 64'h0000_0000_AB00_0000, 0, cyc, sat, gm, rd);
    check("wr_byte_mask_lit", {56'd0, gm}, 64'h08);
    check_xfer("rd_dword", 1'b0, 32'h0, 3'd3, 64'd0, 0, cyc, sat, gm, rd);
    check("rd_dword_lit", rd, 64'h1122_3344_AB66_7788);

    // Error transfers: misaligned halfword, oversized transfer
    check_xfer("err_half", 1'b1, 32'h1, 3'd1, 64'hFFFF, 0, cyc, sat, gm, rd);
    check("err_half_cycles_lit", 64'(cyc), 64'd2);
    check_xfer("err_size", 1'b0, 32'h0, 3'd4, 64'd0, 0, cyc, sat, gm, rd);

    // Starvation: forced grant on the 8th blocked cycle
    check_xfer("rd_starve", 1'b0, 32'h8, 3'd2, 64'd0, 20, cyc, sat, gm, rd);
    check("rd_starve_cycles_lit", 64'(cyc), 64'd9);
    check("rd_starve_stall_at_lit", 64'(sat), 64'd8);
    check_xfer("wr_busy3", 1'b1, 32'h10, 3'd3, 64'h0123_4567_89AB_CDEF, 3, cyc, sat, gm, rd);
    check("wr_busy3_cycles_lit", 64'(cyc), 64'd4);
    check_xfer("wr_busy7", 1'b1, 32'h18, 3'd3, 64'h7777_0000_7777_0000, SL - 1, cyc, sat, gm, rd);
    check_xfer("wr_busy8", 1'b1, 32'h28, 3'd2, 64'h0000_0000_8888_8888, SL, cyc, sat, gm, rd);
    check_xfer("rd_busy7", 1'b0, 32'h18, 3'd3, 64'd0, SL - 1, cyc, sat, gm, rd);

    // Offset wraps modulo the DTIM range
    check_xfer("wr_wrap", 1'b1, 32'h0000_1040, 3'd3, 64'hA5A5_5A5A_0F0F_F0F0, 0, cyc, sat, gm, rd);
    check_xfer("rd_wrap", 1'b0, 32'h40, 3'd3, 64'd0, 0, cyc, sat, gm, rd);
    check("rd_wrap_lit", rd, 64'hA5A5_5A5A_0F0F_F0F0);

    // Pipelined write then read of the same address
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = 3'd3;
    @(posedge clk); #1;
    HWDATA = 64'hFEED_FACE_1234_5678; HADDR = 32'h20; HWRITE = 1'b0; HSIZE = 3'd3;
    sample_cycle();
    check("pipe_wr_ready", {63'd0, HREADYOUT}, 64'd1);
    check("pipe_wr_we", {63'd0, BusDTIMWE}, 64'd1);
    check("pipe_wr_adr", {32'd0, BusDTIMAdr}, 64'h20);
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    sample_cycle();
    check("pipe_rd_wait", {63'd0, HREADYOUT}, 64'd0);
    check("pipe_rd_req", {63'd0, (BusDTIMReq && !BusDTIMWE)}, 64'd1);
    @(posedge clk); #1;
    sample_cycle();
    check("pipe_rd_ready", {63'd0, HREADYOUT}, 64'd1);
    check("pipe_rd_data", HRDATA, 64'hFEED_FACE_1234_5678);
    gold[4] = 64'hFEED_FACE_1234_5678;
    @(posedge clk); #1;

    // Reset while a write is waiting for its slot
    check_xfer("wr_pre_rst", 1'b1, 32'h30, 3'd3, 64'hCAFE_BABE_0000_1111, 0, cyc, sat, gm, rd);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h30; HWRITE = 1'b1; HSIZE = 3'd3;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 64'hDEAD_BEEF_0BAD_F00D; CoreReqM = 1'b1;
    sample_cycle();
    check("rst_wr_blocked", {63'd0, HREADYOUT}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; CoreReqM = 1'b0;
    sample_cycle();
    check("rst_cycle_we", {63'd0, BusDTIMWE}, 64'd0);
    check("rst_cycle_req", {63'd0, BusDTIMReq}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; HWDATA = '0;
    @(negedge clk);
    check_reset_state("after_rst");
    @(posedge clk); #1;
    check_xfer("rd_post_rst", 1'b0, 32'h30, 3'd3, 64'd0, 0, cyc, sat, gm, rd);
    check("rd_post_rst_lit", rd, 64'hCAFE_BABE_0000_1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
